// File: rtl/jt12_bus_writer.sv
// ============================================================================
// jt12_bus_writer
// Queues {part, register, data} commands and plays each one onto the jt12
// CPU write port as an address write followed by a data write. Each command
// waits for the chip busy flag to clear before it starts.
// Optional macro JT12_BUSY_TIMEOUT_EN: abort a command whose busy-wait lasts
// BUSY_TIMEOUT cycles and raise a sticky timeout flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt12_bus_writer #(
    parameter int FIFO_AW       = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int BUSY_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_part,
    input  logic [7:0]         cmd_reg,
    input  logic [7:0]         cmd_data,
    output logic               cs_n,
    output logic               wr_n,
    output logic [1:0]         addr,
    output logic [7:0]         dout,
    input  logic               busy_in,
    output logic               idle,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               timeout
);

    localparam int         c_DEPTH    = 1 << FIFO_AW;
    localparam logic [3:0] c_STB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [15:0] c_BTO_LAST = 16'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAITB = 3'd1,
        S_A_SET = 3'd2,
        S_A_STB = 3'd3,
        S_GAP   = 3'd4,
        S_D_SET = 3'd5,
        S_D_STB = 3'd6,
        S_POST  = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [16:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [16:0]        w_head;

    // Count never exceeds the depth, so its top bit alone marks full.
    assign w_full    = r_count[FIFO_AW];
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid & ~w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign cmd_ready = ~w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {cmd_part, cmd_reg, cmd_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [16:0] r_cur;
    logic        r_cs_n;
    logic        r_wr_n;
    logic [1:0]  r_addr;
    logic [7:0]  r_dout;
    logic        r_idle;
    logic        r_timeout;
    logic        w_bto_hit;

`ifdef JT12_BUSY_TIMEOUT_EN
    logic [15:0] r_bto;
    assign w_bto_hit = (r_bto == c_BTO_LAST);
`else
    logic w_unused_bto;
    assign w_unused_bto = ^c_BTO_LAST;
    assign w_bto_hit    = 1'b0;
`endif

    always_comb begin
        w_pop = 1'b0;
        if ((r_state == S_IDLE || r_state == S_WAITB) && !w_empty && !busy_in) begin
            w_pop = 1'b1;
        end
        // A timed-out head command is discarded rather than issued.
        if (r_state == S_WAITB && busy_in && w_bto_hit) begin
            w_pop = 1'b1;
        end
    end

    // Bus outputs are a registered decode of the current state, so the pins
    // trail the state register by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cur     <= '0;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_addr    <= '0;
            r_dout    <= '0;
            r_idle    <= 1'b1;
            r_timeout <= 1'b0;
`ifdef JT12_BUSY_TIMEOUT_EN
            r_bto     <= '0;
`endif
        end else begin
            r_idle <= (r_state == S_IDLE) && w_empty;
            case (r_state)
                S_IDLE: begin
                    r_cs_n <= 1'b1;
                    r_wr_n <= 1'b1;
                    r_cnt  <= '0;
                    if (!w_empty) begin
                        if (!busy_in) begin
                            r_cur   <= w_head;
                            r_state <= S_A_SET;
                        end else begin
                            r_state <= S_WAITB;
`ifdef JT12_BUSY_TIMEOUT_EN
                            r_bto   <= '0;
`endif
                        end
                    end
                end
                S_WAITB: begin
                    r_cs_n <= 1'b1;
                    r_wr_n <= 1'b1;
                    if (!busy_in) begin
                        r_cur   <= w_head;
                        r_state <= S_A_SET;
                    end
`ifdef JT12_BUSY_TIMEOUT_EN
                    else if (w_bto_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_bto <= r_bto + 16'd1;
                    end
`endif
                end
                S_A_SET: begin
                    r_cs_n  <= 1'b0;
                    r_wr_n  <= 1'b1;
                    r_addr  <= {r_cur[16], 1'b0};
                    r_dout  <= r_cur[15:8];
                    r_cnt   <= c_STB_LAST;
                    r_state <= S_A_STB;
                end
                S_A_STB: begin
                    r_cs_n <= 1'b0;
                    r_wr_n <= 1'b0;
                    if (r_cnt == '0) begin
                        r_cnt   <= c_STB_LAST;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    r_cs_n <= 1'b1;
                    r_wr_n <= 1'b1;
                    if (r_cnt == '0) begin
                        r_cnt   <= '0;
                        r_state <= S_D_SET;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_D_SET: begin
                    r_cs_n  <= 1'b0;
                    r_wr_n  <= 1'b1;
                    r_addr  <= {r_cur[16], 1'b1};
                    r_dout  <= r_cur[7:0];
                    r_cnt   <= c_STB_LAST;
                    r_state <= S_D_STB;
                end
                S_D_STB: begin
                    r_cs_n <= 1'b0;
                    r_wr_n <= 1'b0;
                    if (r_cnt == '0) begin
                        r_cnt   <= 4'd1;
                        r_state <= S_POST;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_POST: begin
                    // Two quiet cycles give the chip time to raise busy.
                    r_cs_n <= 1'b1;
                    r_wr_n <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cs_n       = r_cs_n;
    assign wr_n       = r_wr_n;
    assign addr       = r_addr;
    assign dout       = r_dout;
    assign idle       = r_idle;
    assign fifo_level = r_count;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_jt12_bus_writer.sv
// ============================================================================
// tb_jt12_bus_writer
// Directed self-checking bench for jt12_bus_writer (STROBE_CYCLES=2, FIFO_AW=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jt12_bus_writer;

    localparam int FIFO_AW = 2;
`ifdef JT12_BUSY_TIMEOUT_EN
    localparam int BUSY_HOLD = 15;
`else
    localparam int BUSY_HOLD = 40;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_part = 1'b0;
    logic [7:0]       cmd_reg = 8'h00;
    logic [7:0]       cmd_data = 8'h00;
    logic             cs_n;
    logic             wr_n;
    logic [1:0]       addr;
    logic [7:0]       dout;
    logic             busy_in = 1'b0;
    logic             idle;
    logic [FIFO_AW:0] fifo_level;
    logic             timeout;

    int n_checks = 0;
    int n_errors = 0;

    jt12_bus_writer #(
        .FIFO_AW       (FIFO_AW),
        .STROBE_CYCLES (2),
        .BUSY_TIMEOUT  (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_part   (cmd_part),
        .cmd_reg    (cmd_reg),
        .cmd_data   (cmd_data),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .addr       (addr),
        .dout       (dout),
        .busy_in    (busy_in),
        .idle       (idle),
        .fifo_level (fifo_level),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_part  = p;
        cmd_reg   = r;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cs(input logic val, input string tag);
        int n;
        n = 0;
        while (cs_n !== val && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(cs_n), 32'(val));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    task automatic observe_cmd(input string tag, input logic p, input logic [7:0] r,
                               input logic [7:0] d, input logic [FIFO_AW:0] lvl);
        wait_cs(1'b0, {tag, "_a_start"});
        chk({tag, "_a_bus"}, 32'({addr, dout}), 32'({p, 1'b0, r}));
        chk({tag, "_level"}, 32'(fifo_level), 32'(lvl));
        wait_cs(1'b1, {tag, "_gap"});
        wait_cs(1'b0, {tag, "_d_start"});
        chk({tag, "_d_bus"}, 32'({addr, dout}), 32'({p, 1'b1, d}));
        wait_cs(1'b1, {tag, "_end"});
    endtask

    // {cs_n, wr_n, addr, dout} after each edge following the pop of {0,28,F1}
    logic [11:0] exp2 [12] = '{12'hC00, 12'h428, 12'h028, 12'h028, 12'hC28, 12'hC28,
                               12'h5F1, 12'h1F1, 12'h1F1, 12'hDF1, 12'hDF1, 12'hDF1};

    initial begin
        int  n;
        logic cs_fell;

        // 1. Reset
        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bus", 32'({addr, dout, timeout}), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2. Single write
        push(1'b0, 8'h28, 8'hF1);
        chk("t2_level_push", 32'(fifo_level), 32'd1);
        chk("t2_idle_push", 32'(idle), 32'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("t2_bus_k%0d", k + 1), 32'({cs_n, wr_n, addr, dout}), 32'(exp2[k]));
            if (k == 0)  chk("t2_level_pop", 32'(fifo_level), 32'd0);
            if (k == 10) chk("t2_idle_k11", 32'(idle), 32'd0);
            if (k == 11) chk("t2_idle_k12", 32'(idle), 32'd1);
        end

        // 3. Busy gating
        busy_in = 1'b1;
        push(1'b1, 8'hB0, 8'h32);
        cs_fell = 1'b0;
        for (int k = 0; k < BUSY_HOLD; k++) begin
            tick();
            if (cs_n !== 1'b1) cs_fell = 1'b1;
        end
        chk("t3_cs_held_busy", 32'(cs_fell), 32'd0);
        chk("t3_level_busy", 32'(fifo_level), 32'd1);
        busy_in = 1'b0;
        tick();
        chk("t3_cs_pop_edge", 32'(cs_n), 32'd1);
        chk("t3_level_pop", 32'(fifo_level), 32'd0);
        tick();
        chk("t3_a_bus", 32'({cs_n, wr_n, addr, dout}), 32'({2'b01, 2'd2, 8'hB0}));
        repeat (5) tick();
        chk("t3_d_bus", 32'({cs_n, wr_n, addr, dout}), 32'({2'b01, 2'd3, 8'h32}));
        tick();
        chk("t3_d_strobe", 32'({cs_n, wr_n}), 32'b00);
        wait_idle("t3_idle");

        // 4. FIFO full
        busy_in = 1'b1;
        push(1'b0, 8'h10, 8'hA0);
        push(1'b1, 8'h11, 8'hA1);
        push(1'b0, 8'h12, 8'hA2);
        push(1'b1, 8'h13, 8'hA3);
        push(1'b0, 8'h14, 8'hA4);
        chk("t4_level_full", 32'(fifo_level), 32'd4);
        chk("t4_ready_full", 32'(cmd_ready), 32'd0);
        chk("t4_cs_busy", 32'(cs_n), 32'd1);
        busy_in = 1'b0;
        observe_cmd("t4_c0", 1'b0, 8'h10, 8'hA0, 3'd3);
        observe_cmd("t4_c1", 1'b1, 8'h11, 8'hA1, 3'd2);
        observe_cmd("t4_c2", 1'b0, 8'h12, 8'hA2, 3'd1);
        observe_cmd("t4_c3", 1'b1, 8'h13, 8'hA3, 3'd0);
        wait_idle("t4_idle");
        chk("t4_ready_after", 32'(cmd_ready), 32'd1);

        // 5. Reset during the data strobe
        push(1'b0, 8'h30, 8'h77);
        push(1'b1, 8'h31, 8'h88);
        n = 0;
        while (!(cs_n === 1'b0 && wr_n === 1'b0 && addr[0] === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_d_stb_seen", 32'({cs_n, wr_n, addr[0]}), 32'b001);
        chk("t5_level_before", 32'(fifo_level), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_strobes", 32'({cs_n, wr_n}), 32'b11);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_level_after", 32'(fifo_level), 32'd0);
        chk("t5_idle_after", 32'(idle), 32'd1);
        repeat (4) tick();
        chk("t5_no_resume", 32'({cs_n, wr_n}), 32'b11);

        // 6. Busy stuck high
        busy_in = 1'b1;
        push(1'b0, 8'h20, 8'h55);
        push(1'b1, 8'h21, 8'h66);
`ifdef JT12_BUSY_TIMEOUT_EN
        repeat (19) tick();
        chk("t6_to_before", 32'(timeout), 32'd0);
        tick();
        chk("t6_to_set", 32'(timeout), 32'd1);
        chk("t6_level_drop", 32'(fifo_level), 32'd1);
        repeat (5) tick();
        chk("t6_cs_waiting", 32'(cs_n), 32'd1);
        busy_in = 1'b0;
        observe_cmd("t6_next", 1'b1, 8'h21, 8'h66, 3'd0);
        chk("t6_to_sticky", 32'(timeout), 32'd1);
`else
        repeat (30) tick();
        chk("t6_to_clear", 32'(timeout), 32'd0);
        chk("t6_level_kept", 32'(fifo_level), 32'd2);
        chk("t6_cs_waiting", 32'(cs_n), 32'd1);
        busy_in = 1'b0;
        observe_cmd("t6_c0", 1'b0, 8'h20, 8'h55, 3'd1);
        observe_cmd("t6_c1", 1'b1, 8'h21, 8'h66, 3'd0);
        chk("t6_to_final", 32'(timeout), 32'd0);
`endif
        wait_idle("t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/jt12_bus_writer.md
Name: jt12_bus_writer

Overview:
- Bus-master sequencer that drives the jt12 CPU write port (cs_n/wr_n/addr/din) from a queue of register-write commands.
- Each command is {part, register, data}. It is issued as an address write followed by a data write.
- Before each address write, the block waits for the chip's busy flag to clear.
- Sits between a host (or test sequencer) and jt12_mmr. It replaces hand-timed bus stimulus.

Parameters:
- FIFO_AW, 2, log2 of command FIFO depth (depth = 2**FIFO_AW).
- STROBE_CYCLES, 2, cycles wr_n held low per write; also the gap between the address and data writes; range 1..15.
- BUSY_TIMEOUT, 255, maximum busy-wait cycles before abort (only with the optional feature); range 1..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host offers a command
- cmd_ready  out  1  FIFO can accept; push when cmd_valid & cmd_ready
- cmd_part  in  1  0 = registers 0x00-0xFF part I, 1 = part II
- cmd_reg  in  8  register address
- cmd_data  in  8  register value
- cs_n  out  1  chip select to jt12
- wr_n  out  1  write strobe to jt12
- addr  out  2  {part, 0} for address phase; {part, 1} for data phase
- dout  out  8  bus data to jt12 din
- busy_in  in  1  jt12 busy (status bit 7)
- idle  out  1  FIFO empty and FSM in IDLE
- fifo_level  out  FIFO_AW+1  number of queued commands
- timeout  out  1  sticky busy-wait timeout flag

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low, and applies to all state.
- Reset values: cs_n=1, wr_n=1, addr=0, dout=0, cmd_ready=1, idle=1, fifo_level=0, timeout=0. FIFO is emptied and the FSM goes to IDLE. All outputs are registered except cmd_ready = !full.
- FIFO: first-word-fall-through.
  - Push when cmd_valid & cmd_ready; the entry is visible the next cycle.
  - Pop happens on the IDLE/WAITB -> A_SET transition.
  - Simultaneous push and pop when not full: both occur and the level is unchanged.
  - Push while full is ignored (cmd_ready=0). Pop while empty never happens.
  - Pointers wrap modulo depth.
- FSM states: IDLE, WAITB, A_SET, A_STB, GAP, D_SET, D_STB, POST.
- IDLE: if the FIFO is non-empty and busy_in=0, pop and go to A_SET. If non-empty and busy_in=1, go to WAITB.
- WAITB: stay while busy_in=1. Pop and go to A_SET when busy_in=0.
- A_SET (1 cycle): cs_n=0, wr_n=1, addr={part,0}, dout=reg.
- A_STB (STROBE_CYCLES cycles): wr_n=0; addr and dout held.
- GAP (STROBE_CYCLES cycles): cs_n=1, wr_n=1; addr and dout held.
- D_SET (1 cycle): cs_n=0, addr={part,1}, dout=data.
- D_STB (STROBE_CYCLES cycles): wr_n=0.
- POST (2 cycles): cs_n=1, wr_n=1. This lets busy_in rise before it is next sampled. Then go to IDLE.
- Latency: a command pushed at edge N into an empty FIFO with busy_in=0 gives cs_n low after edge N+2. One complete command occupies 2*STROBE_CYCLES+STROBE_CYCLES+2+2 cycles from A_SET to return to IDLE.
- Back-to-back commands: after POST, IDLE re-checks busy_in, so consecutive writes are always separated by busy deassertion.
- Strobe counter is 4 bits and reloads on every state entry.
- idle = (state==IDLE) & empty, registered.
- Reset mid-operation: cs_n/wr_n return to 1 immediately (asynchronously). The partially issued command is lost.

Optional Feature:
- Macro: JT12_BUSY_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAITB.
  - If busy_in stays 1 for BUSY_TIMEOUT consecutive cycles, the head command is popped and discarded, timeout is set to 1, and the FSM returns to IDLE.
  - timeout is sticky until rst_n.
- Undefined: WAITB waits indefinitely and timeout is constant 0.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> cs_n=1, wr_n=1, fifo_level=0, idle=1, cmd_ready=1.
2. Single write, STROBE_CYCLES=2, busy_in=0:
   - Stimulus: push {part 0, reg 0x28, data 0xF1}.
   - Required bus sequence: addr=0 with dout=0x28 and wr_n low 2 cycles; cs_n high 2 cycles; addr=1 with dout=0xF1 and wr_n low 2 cycles.
   - idle returns to 1 after 11 cycles.
3. Busy gating:
   - Stimulus: drive busy_in=1 for 40 cycles after the first data write, then push a second command {part 1, reg 0xB0, data 0x32}.
   - Required: cs_n does not fall until 1 cycle after busy_in=0; second command is issued with addr=2 then 3.
4. FIFO full, FIFO_AW=2, busy_in=1:
   - Stimulus: push 5 commands.
   - Required: 4 accepted, fifo_level=4, cmd_ready=0.
   - Release busy -> writes come out in push order; level decrements per pop.
5. Reset mid-strobe: assert rst_n=0 during D_STB -> wr_n=1 and cs_n=1 in the same cycle; FIFO empty after release.
6. With JT12_BUSY_TIMEOUT_EN and BUSY_TIMEOUT=20, busy_in stuck at 1:
   - Required: timeout=1 after 20 WAITB cycles, head command discarded, next command waits.
   - Without the macro: timeout stays 0.
